latch_load_ctrl: RTL and testbench

Upstream load sequencer for the 4-bit transparent latch stage (`ena`/`in`/`out`). Accepts data words over a valid/ready handshake and drives the latch's data and gate pins with a programmable data-setup, gate-pulse and data-hold sequence, so that the latch only opens while its D input is stable. One word is loaded per transaction. The block also reports completion and keeps a shadow copy of the last word it committed.

---
 rtl/latch_load_ctrl.sv | 139 +++++++++++++
 tb/tb_latch_load_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_load_ctrl.sv
// Load sequencer for a transparent latch: presents a word, then pulses the latch gate with programmable setup/pulse/hold margins.
// Latency: the gate rises SETUP_CYC edges after acceptance and done pulses SETUP_CYC+PULSE_CYC+HOLD_CYC edges after acceptance.
// Backpressure: s_ready is low from acceptance until completion; one word at a time, no queueing.
module latch_load_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] lat_in,
    output logic             lat_ena,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] last_data
);

    // A gate pulse of zero cycles would never open the latch, and the
    // phase counter is only 8 bits wide.
    if (WIDTH < 1) begin : g_bad_width
        $error("latch_load_ctrl: WIDTH must be at least 1");
    end
    if (PULSE_CYC < 1 || PULSE_CYC > 255) begin : g_bad_pulse
        $error("latch_load_ctrl: PULSE_CYC must be in 1..255");
    end
    if (SETUP_CYC < 0 || SETUP_CYC > 255) begin : g_bad_setup
        $error("latch_load_ctrl: SETUP_CYC must be in 0..255");
    end
    if (HOLD_CYC < 0 || HOLD_CYC > 255) begin : g_bad_hold
        $error("latch_load_ctrl: HOLD_CYC must be in 0..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Counter preload values: each phase runs for N cycles, so the counter
    // starts at N-1 and the phase ends on the edge where it reads zero.
    // The setup/hold preloads are only used when that phase is non-empty.
    localparam logic [7:0] SETUP_INIT = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_INIT = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC - 1);

    state_t     state;
    logic [7:0] cnt;

    // busy follows the state register directly so it clears with the async reset.
    assign busy = (state != IDLE);

    // Sequencer: accepts a word, walks setup/pulse/hold, commits and reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            s_ready   <= 1'b0;
            lat_in    <= '0;
            lat_ena   <= 1'b0;
            done      <= 1'b0;
            last_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_ready) begin
                        // First edge out of reset: open for business,
                        // nothing can be accepted on this edge.
                        s_ready <= 1'b1;
                    end else if (s_valid) begin
                        lat_in  <= s_data;
                        s_ready <= 1'b0;
                        if (SETUP_CYC > 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_INIT;
                        end else begin
                            // No setup margin: gate opens together with the
                            // new data, which is fine for a transparent latch.
                            state   <= PULSE;
                            cnt     <= PULSE_INIT;
                            lat_ena <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (cnt == 8'd0) begin
                        state   <= PULSE;
                        cnt     <= PULSE_INIT;
                        lat_ena <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                PULSE: begin
                    if (cnt == 8'd0) begin
                        // Gate closes: the latch now holds lat_in, so that
                        // is the word committed downstream.
                        lat_ena   <= 1'b0;
                        last_data <= lat_in;
                        if (HOLD_CYC > 0) begin
                            state <= HOLD;
                            cnt   <= HOLD_INIT;
                        end else begin
                            state   <= IDLE;
                            done    <= 1'b1;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (cnt == 8'd0) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        s_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    lat_ena <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_load_ctrl.sv
module tb_latch_load_ctrl;

    localparam int S0 = 1, P0 = 2, H0 = 1;   // default timing
    localparam int S1 = 0, P1 = 1, H1 = 0;   // zero setup / hold

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sv  = 2'b00;
    logic [3:0] sd [2];

    logic       rdy0, ena0, busy0, done0;
    logic [3:0] lin0, last0;
    logic       rdy1, ena1, busy1, done1;
    logic [3:0] lin1, last1;

    always #5 clk = ~clk;

    latch_load_ctrl #(.WIDTH(4), .SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(rdy0),
        .lat_in(lin0), .lat_ena(ena0), .busy(busy0), .done(done0), .last_data(last0)
    );

    latch_load_ctrl #(.WIDTH(4), .SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(rdy1),
        .lat_in(lin1), .lat_ena(ena1), .busy(busy1), .done(done1), .last_data(last1)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;          // edge index

    // Reference model: one outstanding transaction per DUT, described by its
    // acceptance edge; every output follows from the edge offset k.
    bit         act [2];
    int         tacc [2];
    int         prevacc [2];
    logic [3:0] mword [2];
    logic [3:0] mlast [2];
    bit         mrdy [2];
    bit         mena [2];
    bit         mbusy [2];
    bit         mdone [2];
    bit         acc_now [2];
    bit         pdone [2];
    bit         gap = 1'b0;
    bit         b2b = 1'b0;
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];

    function automatic int ps(int d); return (d == 0) ? S0 : S1; endfunction
    function automatic int pp(int d); return (d == 0) ? P0 : P1; endfunction
    function automatic int ph(int d); return (d == 0) ? H0 : H1; endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d]     = 1'b0;
            mrdy[d]    = 1'b0;
            mword[d]   = 4'h0;
            mlast[d]   = 4'h0;
            mena[d]    = 1'b0;
            mbusy[d]   = 1'b0;
            mdone[d]   = 1'b0;
            acc_now[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int k;
        int s, p, h;
        n++;
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                s = ps(d); p = pp(d); h = ph(d);
                acc_now[d] = 1'b0;
                if (!act[d]) begin
                    if (mrdy[d] && sv[d]) begin
                        act[d]     = 1'b1;
                        tacc[d]    = n;
                        mword[d]   = sd[d];
                        acc_now[d] = 1'b1;
                        if (d == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                        if (b2b && prevacc[d] >= 0)
                            chk($sformatf("d%0d_b2b_period", d), n - prevacc[d], s + p + h + 1);
                        prevacc[d] = n;
                    end else begin
                        mrdy[d] = 1'b1;
                    end
                end
                mena[d]  = 1'b0;
                mbusy[d] = 1'b0;
                mdone[d] = 1'b0;
                if (act[d]) begin
                    k        = n - tacc[d];
                    mena[d]  = (k >= s) && (k < s + p);
                    if (k >= s + p) mlast[d] = mword[d];
                    mrdy[d]  = (k >= s + p + h);
                    if (k == s + p + h) begin
                        mdone[d] = 1'b1;
                        act[d]   = 1'b0;
                    end else begin
                        mbusy[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(int d, logic r, logic [3:0] li, logic e, logic b, logic dn, logic [3:0] ld);
        chk($sformatf("d%0d_s_ready", d), r, mrdy[d]);
        chk($sformatf("d%0d_lat_in", d), li, mword[d]);
        chk($sformatf("d%0d_lat_ena", d), e, mena[d]);
        chk($sformatf("d%0d_busy", d), b, mbusy[d]);
        chk($sformatf("d%0d_done", d), dn, mdone[d]);
        chk($sformatf("d%0d_last_data", d), ld, mlast[d]);
        chk($sformatf("d%0d_done_twice", d), pdone[d] & dn, 0);
        if (e === 1'b1)
            chk($sformatf("d%0d_ena_word", d), li, mword[d]);
        pdone[d] = dn;
    endtask

    task automatic chk_zero();
        chk("rst_s_ready", {rdy1, rdy0}, 0);
        chk("rst_lat_in", {lin1, lin0}, 0);
        chk("rst_lat_ena", {ena1, ena0}, 0);
        chk("rst_busy", {busy1, busy0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_last_data", {last1, last0}, 0);
    endtask

    task automatic drive();
        bit has;
        logic [3:0] front;
        for (int d = 0; d < 2; d++) begin
            has   = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            front = 4'h0;
            if (has) front = (d == 0) ? q0[0] : q1[0];
            if (!mrdy[d]) begin
                // ignored while not ready: scramble freely
                sv[d] = 1'($urandom);
                sd[d] = 4'($urandom);
            end else if (has && !(gap && $urandom_range(0, 2) == 0)) begin
                sv[d] = 1'b1;
                sd[d] = front;
            end else begin
                sv[d] = 1'b0;
                sd[d] = 4'($urandom);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_dut(0, rdy0, lin0, ena0, busy0, done0, last0);
        check_dut(1, rdy1, lin1, ena1, busy1, done1, last1);
        drive();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 chk_zero();
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int i;
        sd[0] = 4'h0;
        sd[1] = 4'h0;
        prevacc[0] = -1;
        prevacc[1] = -1;

        // reset from power-up, checked before any clock edge
        #2 rst = 1'b1;
        #1 chk_zero();
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();                       // s_ready rises on this edge

        // single word per DUT
        q0.push_back(4'hA);
        q1.push_back(4'h5);
        repeat (8) cycle();

        // back-to-back with valid held high
        b2b = 1'b1;
        prevacc[0] = -1;
        prevacc[1] = -1;
        q0.push_back(4'h3); q0.push_back(4'hC);
        q1.push_back(4'h5); q1.push_back(4'h6);
        repeat (14) cycle();
        b2b = 1'b0;
        chk("b2b_drained", q0.size() + q1.size(), 0);

        // reset while the gate is open
        q0.push_back(4'h9);
        i = 0;
        while (!acc_now[0] && i < 20) begin
            cycle();
            i++;
        end
        chk("pulse_acc_seen", acc_now[0], 1);
        cycle();
        cycle();
        chk("gate_open_before_rst", ena0, 1);
        async_reset();
        q0.push_back(4'hF);
        q1.push_back(4'h2);
        repeat (10) cycle();
        chk("f_committed", last0, 4'hF);

        // randomized traffic with gaps and junk while busy, one reset mid-run
        gap = 1'b1;
        for (int j = 0; j < 20; j++) begin
            q0.push_back(4'($urandom));
            q1.push_back(4'($urandom));
        end
        repeat (60) cycle();
        async_reset();
        repeat (300) cycle();
        chk("rand_drained", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
